etapa_decodificacion: RTL and testbench

//  Decode stage directly upstream of the register bank: splits a 32-bit MIPS word into fields,

---
 rtl/paquete_decod.sv | 58 +++++
 rtl/marcador_riesgos.sv | 51 +++++
 rtl/etapa_decodificacion.sv | 169 ++++++++++++++++
 tb/tb_etapa_decodificacion.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/paquete_decod.sv
`default_nettype none
// ============================================================================
//  Package    : paquete_decod
//  Description: MIPS opcode constants, field positions and decode helpers
//  Revision   : 1.0 - initial release
// ============================================================================
package paquete_decod;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_SLTI = 6'h0A;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam int C_OP_LSB    = 26;
    localparam int C_RS_LSB    = 21;
    localparam int C_RT_LSB    = 16;
    localparam int C_RD_LSB    = 11;
    localparam int C_FUNCT_LSB = 0;
    localparam int C_ANCHO_OP  = 6;
    localparam int C_ANCHO_IMM = 16;

    localparam logic W_R_ESCRIBIR = 1'b0;
    localparam logic W_R_LEER     = 1'b1;

    typedef enum logic [1:0] {
        DEST_NINGUNO = 2'd0,
        DEST_RD      = 2'd1,
        DEST_RT      = 2'd2
    } sel_dest_e;

    function automatic sel_dest_e destino_de(input logic [5:0] op);
        case (op)
            OP_R:                                   return DEST_RD;
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LW: return DEST_RT;
            default:                                return DEST_NINGUNO;
        endcase
    endfunction

    function automatic logic es_legal(input logic [5:0] op);
        case (op)
            OP_R, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI,
            OP_LW, OP_SW, OP_BEQ, OP_J: return 1'b1;
            default:                    return 1'b0;
        endcase
    endfunction

    // Logical immediates are zero-extended, everything else sign-extended.
    function automatic logic extiende_cero(input logic [5:0] op);
        return (op == OP_ANDI) || (op == OP_ORI);
    endfunction

endpackage
`default_nettype wire

// File: rtl/marcador_riesgos.sv
`default_nettype none
// ============================================================================
//  Module     : marcador_riesgos
//  Description: Pending-destination scoreboard; flags RAW/WAW hazards
//  Revision   : 1.0 - initial release
// ============================================================================
module marcador_riesgos #(
    parameter int ANCHO_DIR = 5,
    parameter int NUM_REG   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 set_en,
    input  logic [ANCHO_DIR-1:0] set_dir,
    input  logic                 clr_en,
    input  logic [ANCHO_DIR-1:0] clr_dir,
    input  logic                 flush_en,
    input  logic [ANCHO_DIR-1:0] flush_dir,
    input  logic [ANCHO_DIR-1:0] rs,
    input  logic [ANCHO_DIR-1:0] rt,
    input  logic [ANCHO_DIR-1:0] rd,
    output logic                 riesgo
);

    localparam logic [NUM_REG-1:0] c_mascara_r0 = {{(NUM_REG-1){1'b1}}, 1'b0};

    logic [NUM_REG-1:0] r_pend;
    logic [NUM_REG-1:0] w_set;
    logic [NUM_REG-1:0] w_clr;

    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (set_en)   w_set[set_dir]   = 1'b1;
        if (clr_en)   w_clr[clr_dir]   = 1'b1;
        if (flush_en) w_clr[flush_dir] = 1'b1;
    end

    // Set dominates clear; r0 is never tracked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend <= '0;
        end else begin
            r_pend <= ((r_pend & ~w_clr) | w_set) & c_mascara_r0;
        end
    end

    assign riesgo = r_pend[rs] | r_pend[rt] | r_pend[rd];

endmodule
`default_nettype wire

// File: rtl/etapa_decodificacion.sv
`default_nettype none
// ============================================================================
//  Module     : etapa_decodificacion
//  Description: MIPS decode stage with hazard stall and bank write port.
//               Define DECOD_MARCADOR_EN to enable the RAW/WAW scoreboard.
//  Revision   : 1.0 - initial release
// ============================================================================
module etapa_decodificacion
    import paquete_decod::*;
#(
    parameter int ANCHO_DATO = 32,
    parameter int ANCHO_DIR  = 5,
    parameter int NUM_REG    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ANCHO_DATO-1:0] instr,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    input  logic                  flush,
    output logic [ANCHO_DIR-1:0]  dato_1,
    output logic [ANCHO_DIR-1:0]  dato_2,
    output logic [ANCHO_DIR-1:0]  dest,
    output logic [ANCHO_DATO-1:0] inmediato,
    output logic [5:0]            opcode,
    output logic [5:0]            funct,
    output logic                  ilegal,
    input  logic                  wb_valid,
    input  logic [ANCHO_DIR-1:0]  wb_dir,
    input  logic [ANCHO_DATO-1:0] wb_dato,
    output logic                  w_r,
    output logic [ANCHO_DIR-1:0]  direccion,
    output logic [ANCHO_DATO-1:0] dato
);

    logic [5:0]             w_op;
    logic [5:0]             w_funct;
    logic [ANCHO_DIR-1:0]   w_rs;
    logic [ANCHO_DIR-1:0]   w_rt;
    logic [ANCHO_DIR-1:0]   w_rd;
    logic [C_ANCHO_IMM-1:0] w_imm;
    logic [ANCHO_DIR-1:0]   w_dest;
    logic [ANCHO_DATO-1:0]  w_inm;
    logic                   w_ilegal;
    logic                   w_riesgo;
    logic                   w_acepta;
    logic                   w_wb_escribe;

    logic                   r_out_valid;
    logic [ANCHO_DIR-1:0]   r_dato_1;
    logic [ANCHO_DIR-1:0]   r_dato_2;
    logic [ANCHO_DIR-1:0]   r_dest;
    logic [ANCHO_DATO-1:0]  r_inm;
    logic [5:0]             r_opcode;
    logic [5:0]             r_funct;
    logic                   r_ilegal;
    logic                   r_w_r;
    logic [ANCHO_DIR-1:0]   r_direccion;
    logic [ANCHO_DATO-1:0]  r_dato;

    assign w_op    = instr[C_OP_LSB    +: C_ANCHO_OP];
    assign w_funct = instr[C_FUNCT_LSB +: 6];
    assign w_rs    = instr[C_RS_LSB    +: ANCHO_DIR];
    assign w_rt    = instr[C_RT_LSB    +: ANCHO_DIR];
    assign w_rd    = instr[C_RD_LSB    +: ANCHO_DIR];
    assign w_imm   = instr[0           +: C_ANCHO_IMM];

    always_comb begin
        w_dest   = '0;
        w_ilegal = !es_legal(w_op);
        w_inm    = {{(ANCHO_DATO-C_ANCHO_IMM){w_imm[C_ANCHO_IMM-1]}}, w_imm};
        case (destino_de(w_op))
            DEST_RD: w_dest = w_rd;
            DEST_RT: w_dest = w_rt;
            default: w_dest = '0;
        endcase
        if (w_op == OP_R) begin
            w_inm = '0;
        end else if (extiende_cero(w_op)) begin
            w_inm = {{(ANCHO_DATO-C_ANCHO_IMM){1'b0}}, w_imm};
        end
    end

`ifdef DECOD_MARCADOR_EN
    // A flushed bundle never reaches write-back, so its pending bit is released here.
    marcador_riesgos #(
        .ANCHO_DIR (ANCHO_DIR),
        .NUM_REG   (NUM_REG)
    ) u_marcador (
        .clk       (clk),
        .rst       (rst),
        .set_en    (w_acepta && (w_dest != '0)),
        .set_dir   (w_dest),
        .clr_en    (wb_valid),
        .clr_dir   (wb_dir),
        .flush_en  (flush && r_out_valid && (r_dest != '0)),
        .flush_dir (r_dest),
        .rs        (w_rs),
        .rt        (w_rt),
        .rd        (w_dest),
        .riesgo    (w_riesgo)
    );
`else
    assign w_riesgo = 1'b0;
`endif

    assign in_ready = (!r_out_valid || out_ready) && !w_riesgo && !flush;
    assign w_acepta = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_dato_1    <= '0;
            r_dato_2    <= '0;
            r_dest      <= '0;
            r_inm       <= '0;
            r_opcode    <= '0;
            r_funct     <= '0;
            r_ilegal    <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_acepta) begin
            r_out_valid <= 1'b1;
            r_dato_1    <= w_rs;
            r_dato_2    <= w_rt;
            r_dest      <= w_dest;
            r_inm       <= w_inm;
            r_opcode    <= w_op;
            r_funct     <= w_funct;
            r_ilegal    <= w_ilegal;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // r0 and addresses outside the tracked bank are dropped.
    assign w_wb_escribe = wb_valid && (wb_dir != '0)
                       && ({{(32-ANCHO_DIR){1'b0}}, wb_dir} < 32'(NUM_REG));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_w_r       <= W_R_LEER;
            r_direccion <= '0;
            r_dato      <= '0;
        end else if (w_wb_escribe) begin
            r_w_r       <= W_R_ESCRIBIR;
            r_direccion <= wb_dir;
            r_dato      <= wb_dato;
        end else begin
            r_w_r       <= W_R_LEER;
        end
    end

    assign out_valid = r_out_valid;
    assign dato_1    = r_dato_1;
    assign dato_2    = r_dato_2;
    assign dest      = r_dest;
    assign inmediato = r_inm;
    assign opcode    = r_opcode;
    assign funct     = r_funct;
    assign ilegal    = r_ilegal;
    assign w_r       = r_w_r;
    assign direccion = r_direccion;
    assign dato      = r_dato;

endmodule
`default_nettype wire

// File: tb/tb_etapa_decodificacion.sv
`default_nettype none
// ============================================================================
//  Module     : tb_etapa_decodificacion
//  Description: Self-checking bench for etapa_decodificacion (vector table +
//               handshake/hazard/flush/reset sequences, queue scoreboard)
//  Revision   : 1.0 - initial release
// ============================================================================
module tb_etapa_decodificacion;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic        in_valid;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic        flush;
    logic [4:0]  dato_1;
    logic [4:0]  dato_2;
    logic [4:0]  dest;
    logic [31:0] inmediato;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        ilegal;
    logic        wb_valid;
    logic [4:0]  wb_dir;
    logic [31:0] wb_dato;
    logic        w_r;
    logic [4:0]  direccion;
    logic [31:0] dato;

    etapa_decodificacion dut (
        .clk       (clk),
        .rst       (rst),
        .instr     (instr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .flush     (flush),
        .dato_1    (dato_1),
        .dato_2    (dato_2),
        .dest      (dest),
        .inmediato (inmediato),
        .opcode    (opcode),
        .funct     (funct),
        .ilegal    (ilegal),
        .wb_valid  (wb_valid),
        .wb_dir    (wb_dir),
        .wb_dato   (wb_dato),
        .w_r       (w_r),
        .direccion (direccion),
        .dato      (dato)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [5:0]  op;
        logic [5:0]  funct;
        logic [4:0]  dest;
        logic [4:0]  d1;
        logic [4:0]  d2;
        logic [31:0] inm;
        logic        ilegal;
    } vec_t;

    vec_t tbl [12];
    vec_t exp_q [$];
    vec_t cur_exp;
    vec_t v_add3, v_sub4, v_addi7;
    int   checks = 0;
    int   errors = 0;
    logic        exp_wr;
    logic [4:0]  exp_dir;
    logic [31:0] exp_dato;

    function automatic vec_t mk(input logic [31:0] i, input logic [5:0] op, input logic [5:0] f,
                                input logic [4:0] de, input logic [4:0] a, input logic [4:0] b,
                                input logic [31:0] im, input logic il);
        vec_t v;
        v.instr = i; v.op = op; v.funct = f; v.dest = de;
        v.d1 = a; v.d2 = b; v.inm = im; v.ilegal = il;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    // Accepted instructions are queued from the handshake seen just before the edge.
    task automatic tick();
        #1;
        if (!rst && in_valid && in_ready) exp_q.push_back(cur_exp);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input vec_t v);
        instr    = v.instr;
        in_valid = 1'b1;
        cur_exp  = v;
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!in_ready && n < 32) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL %s timeout actual=in_ready_0 required=in_ready_1", name);
        end
    endtask

    task automatic check_bundle(input string tag);
        vec_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s bundle_missing actual=empty required=entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_dest"},   32'(dest),      32'(e.dest));
            chk({tag, "_inm"},    inmediato,      e.inm);
            chk({tag, "_opcode"}, 32'(opcode),    32'(e.op));
            chk({tag, "_funct"},  32'(funct),     32'(e.funct));
            chk({tag, "_ilegal"}, 32'(ilegal),    32'(e.ilegal));
            chk({tag, "_dato1"},  32'(dato_1),    32'(e.d1));
            chk({tag, "_dato2"},  32'(dato_2),    32'(e.d2));
        end
    endtask

    task automatic wb_pulse(input logic [4:0] dir);
        wb_valid = 1'b1;
        wb_dir   = dir;
        wb_dato  = $urandom;
        tick();
        wb_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; instr = '0; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        wb_valid = 1'b0; wb_dir = '0; wb_dato = '0;

        tbl[0]  = mk(32'hFC858000, 6'h3F, 6'h00, 5'd0,  5'd4,  5'd5,  32'hFFFF8000, 1'b1);
        tbl[1]  = mk(32'h2005FFFD, 6'h08, 6'h3D, 5'd5,  5'd0,  5'd5,  32'hFFFFFFFD, 1'b0);
        tbl[2]  = mk(32'h34068000, 6'h0D, 6'h00, 5'd6,  5'd0,  5'd6,  32'h00008000, 1'b0);
        tbl[3]  = mk(32'h00221820, 6'h00, 6'h20, 5'd3,  5'd1,  5'd2,  32'h00000000, 1'b0);
        tbl[4]  = mk(32'h8D28FFFC, 6'h23, 6'h3C, 5'd8,  5'd9,  5'd8,  32'hFFFFFFFC, 1'b0);
        tbl[5]  = mk(32'hAD6A0010, 6'h2B, 6'h10, 5'd0,  5'd11, 5'd10, 32'h00000010, 1'b0);
        tbl[6]  = mk(32'h1022FFFF, 6'h04, 6'h3F, 5'd0,  5'd1,  5'd2,  32'hFFFFFFFF, 1'b0);
        tbl[7]  = mk(32'h30E7F0F0, 6'h0C, 6'h30, 5'd7,  5'd7,  5'd7,  32'h0000F0F0, 1'b0);
        tbl[8]  = mk(32'h29AC8001, 6'h0A, 6'h01, 5'd12, 5'd13, 5'd12, 32'hFFFF8001, 1'b0);
        tbl[9]  = mk(32'h08123456, 6'h02, 6'h16, 5'd0,  5'd0,  5'd18, 32'h00003456, 1'b0);
        tbl[10] = mk(32'h00612022, 6'h00, 6'h22, 5'd4,  5'd3,  5'd1,  32'h00000000, 1'b0);
        tbl[11] = mk(32'h00000000, 6'h00, 6'h00, 5'd0,  5'd0,  5'd0,  32'h00000000, 1'b0);
        v_add3  = tbl[3];
        v_sub4  = tbl[10];
        v_addi7 = mk(32'h20A70001, 6'h08, 6'h01, 5'd7, 5'd5, 5'd7, 32'h00000001, 1'b0);

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_w_r",       32'(w_r),       32'd1);
        chk("rst_direccion", 32'(direccion), 32'd0);
        chk("rst_dato",      dato,           32'd0);
        chk("rst_dest",      32'(dest),      32'd0);
        chk("rst_inmediato", inmediato,      32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        rst = 1'b0;
        exp_dir  = '0;
        exp_dato = '0;

        // Decode table; each destination is retired right after issue
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i]);
            #1 chk("tbl_in_ready", 32'(in_ready), 32'd1);
            wait_ready("tbl_accept");
            tick();
            in_valid = 1'b0;
            chk("tbl_out_valid", 32'(out_valid), 32'd1);
            check_bundle("tbl");
            wb_valid = 1'b1;
            wb_dir   = tbl[i].dest;
            wb_dato  = $urandom;
            if (tbl[i].dest != 5'd0) begin
                exp_wr   = 1'b0;
                exp_dir  = tbl[i].dest;
                exp_dato = wb_dato;
            end else begin
                exp_wr   = 1'b1;
            end
            tick();
            wb_valid = 1'b0;
            chk("tbl_drain_valid", 32'(out_valid), 32'd0);
            chk("tbl_w_r",         32'(w_r),       32'(exp_wr));
            chk("tbl_direccion",   32'(direccion), 32'(exp_dir));
            chk("tbl_dato",        dato,           exp_dato);
        end

        // Bank write port: write, then r0 dropped with address/data held
        wb_valid = 1'b1; wb_dir = 5'd7; wb_dato = 32'h12345678;
        tick();
        chk("wb7_w_r",       32'(w_r),       32'd0);
        chk("wb7_direccion", 32'(direccion), 32'd7);
        chk("wb7_dato",      dato,           32'h12345678);
        wb_dir = 5'd0; wb_dato = 32'hDEADBEEF;
        tick();
        wb_valid = 1'b0;
        chk("wb0_w_r",       32'(w_r),       32'd1);
        chk("wb0_direccion", 32'(direccion), 32'd7);
        chk("wb0_dato",      dato,           32'h12345678);

        // add $3,$1,$2 followed by dependent sub $4,$3,$1
        drive(v_add3);
        tick();
        chk("raw_add_valid", 32'(out_valid), 32'd1);
        check_bundle("raw_add");
        drive(v_sub4);
`ifdef DECOD_MARCADOR_EN
        #1 chk("raw_stall", 32'(in_ready), 32'd0);
        tick();
        chk("raw_stall2",     32'(in_ready),  32'd0);
        chk("raw_add_fired",  32'(out_valid), 32'd0);
        wb_valid = 1'b1; wb_dir = 5'd3; wb_dato = 32'h0BADF00D;
        #1 chk("raw_no_bypass", 32'(in_ready), 32'd0);
        tick();
        wb_valid = 1'b0;
        #1 chk("raw_after_clear", 32'(in_ready), 32'd1);
        tick();
`else
        #1 chk("raw_back_to_back", 32'(in_ready), 32'd1);
        tick();
`endif
        in_valid = 1'b0;
        chk("raw_sub_valid", 32'(out_valid), 32'd1);
        check_bundle("raw_sub");
        wb_pulse(5'd4);

        // Held bundle under back-pressure, then flushed
        out_ready = 1'b0;
        drive(tbl[1]);
        #1 chk("hold_first_ready", 32'(in_ready), 32'd1);
        tick();
        chk("hold_out_valid", 32'(out_valid), 32'd1);
        check_bundle("hold");
        drive(tbl[2]);
        for (int k = 0; k < 3; k++) begin
            #1 chk("hold_in_ready", 32'(in_ready), 32'd0);
            tick();
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_dest",  32'(dest),      32'd5);
            chk("hold_inm",   inmediato,      32'hFFFFFFFD);
            chk("hold_dato2", 32'(dato_2),    32'd5);
        end
        flush = 1'b1;
        #1 chk("flush_block", 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0;
        chk("flush_valid",     32'(out_valid),    32'd0);
        chk("flush_no_accept", 32'(exp_q.size()), 32'd0);
        out_ready = 1'b1;
        drive(v_addi7);
        #1 chk("flush_releases_pend", 32'(in_ready), 32'd1);
        wait_ready("flush_dep_accept");
        tick();
        in_valid = 1'b0;
        chk("flush_dep_valid", 32'(out_valid), 32'd1);
        check_bundle("flush_dep");
        wb_pulse(5'd7);

        // Reset in the middle of a stall with a write pending
        out_ready = 1'b0;
        drive(v_add3);
        wb_valid = 1'b1; wb_dir = 5'd9; wb_dato = 32'hA5A5A5A5;
        tick();
        wb_valid = 1'b0;
        chk("prerst_w_r",   32'(w_r),       32'd0);
        chk("prerst_valid", 32'(out_valid), 32'd1);
        check_bundle("prerst");
        drive(v_sub4);
        #1 chk("prerst_stall", 32'(in_ready), 32'd0);
        rst = 1'b1;
        #1;
        chk("rst_mid_valid",     32'(out_valid), 32'd0);
        chk("rst_mid_w_r",       32'(w_r),       32'd1);
        chk("rst_mid_direccion", 32'(direccion), 32'd0);
        chk("rst_mid_dato",      dato,           32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        #1 chk("postrst_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("postrst_valid", 32'(out_valid), 32'd1);
        check_bundle("postrst");
        wb_pulse(5'd4);
        chk("final_idle_valid", 32'(out_valid),    32'd0);
        chk("final_queue",      32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
